// File: rtl/pixel_sink_if.sv
// pixel_sink_if: framebuffer write port (master drives addr/data/we, slave returns ready)
//   mem_addr  ADDR_W  write address
//   mem_data  3       write colour
//   mem_we    1       write valid, held until accepted
//   mem_ready 1       write accepted on mem_we & mem_ready
interface pixel_sink_if #(parameter int ADDR_W = 15) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;
  logic              mem_we;
  logic              mem_ready;
  modport master (output mem_addr, mem_data, mem_we, input mem_ready);
  modport slave  (input mem_addr, mem_data, mem_we, output mem_ready);
endinterface

// File: rtl/pixel_sink.sv
// pixel_sink: bounds-checks plotted pixels, buffers them in a FIFO and writes them to the framebuffer; also full-screen clear
//   clk, reset (async, active-high)
//   x_in/y_in/colour_in/plot_in  pixel stream, one pixel per plot_in cycle
//   clear_req/clear_colour       request a full-screen clear in the given colour
//   mem                          framebuffer write port (pixel_sink_if master)
//   busy      FIFO non-empty, write in flight, or clear pending/active
//   overflow  sticky, a pixel was dropped on a full FIFO
//   offscreen one-cycle pulse after an out-of-range pixel
module pixel_sink #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        x_in,
  input  logic [10:0]        y_in,
  input  logic [2:0]         colour_in,
  input  logic               plot_in,
  input  logic               clear_req,
  input  logic [2:0]         clear_colour,
  pixel_sink_if.master       mem,
  output logic               busy,
  output logic               overflow,
  output logic               offscreen
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  state_t            state;
  logic [ADDR_W+2:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              clear_pend;
  logic [2:0]        clear_col;
  logic [2:0]        cur_col;
  logic              in_range, nonempty, accept, pop, push;
  logic [ADDR_W-1:0] addr;
  always_comb begin
    in_range = (x_in < 12'(H_RES)) && (y_in < 11'(V_RES));
    addr     = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(x_in);
    nonempty = count != '0;
    accept   = mem.mem_we & mem.mem_ready;
    pop      = nonempty & ((state == IDLE) | ((state == WRITE) & accept));
    push     = plot_in & in_range & ((count != FULL) | pop);
    cur_col  = clear_req ? clear_colour : clear_col;
  end
  assign busy = (state != IDLE) | nonempty | clear_pend;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {addr, colour_in};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      offscreen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      overflow  <= overflow | (plot_in & in_range & ~push);
      offscreen <= plot_in & ~in_range;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      mem.mem_addr <= '0;
      mem.mem_data <= '0;
      mem.mem_we   <= 1'b0;
      clear_pend   <= 1'b0;
      clear_col    <= '0;
    end else begin
      if (clear_req) begin
        clear_col  <= clear_colour;
        clear_pend <= 1'b1;
      end
      case (state)
        IDLE:
          if (nonempty) begin
            {mem.mem_addr, mem.mem_data} <= fifo[rd_ptr];
            mem.mem_we <= 1'b1;
            state      <= WRITE;
          end else if (clear_pend) begin
            mem.mem_addr <= '0;
            mem.mem_data <= cur_col;
            mem.mem_we   <= 1'b1;
            state        <= CLEAR;
          end
        WRITE:
          if (accept) begin
            if (nonempty) {mem.mem_addr, mem.mem_data} <= fifo[rd_ptr];
            else begin
              mem.mem_we <= 1'b0;
              state      <= IDLE;
            end
          end
        CLEAR:
          if (accept) begin
            if (mem.mem_addr == LAST) begin
              mem.mem_we <= 1'b0;
              clear_pend <= 1'b0;
              state      <= IDLE;
            end else begin
              mem.mem_addr <= mem.mem_addr + 1'b1;
              mem.mem_data <= cur_col;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pixel_sink.sv
// tb_pixel_sink: directed stimulus with a write scoreboard for pixel_sink
module tb_pixel_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] x_in;
  logic [10:0] y_in;
  logic [2:0]  colour_in;
  logic        plot_in;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        busy, overflow, offscreen;
  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q [$];
  pixel_sink_if #(.ADDR_W(15)) mem ();
  pixel_sink dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot_in(plot_in), .clear_req(clear_req), .clear_colour(clear_colour),
    .mem(mem), .busy(busy), .overflow(overflow), .offscreen(offscreen)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask
  task automatic expect_wr(input int a, input int d);
    exp_q.push_back({15'(a), 3'(d)});
  endtask
  // a write is accepted at the next rising edge; compare it mid-cycle
  always @(negedge clk)
    if (mem.mem_we && mem.mem_ready) begin
      if (exp_q.size() == 0) chk("unexpected_write_addr", 32'(mem.mem_addr), 32'hFFFF_FFFF);
      else chk("write_addr_data", 32'({mem.mem_addr, mem.mem_data}), 32'(exp_q.pop_front()));
    end
  initial begin
    reset = 1'b1; x_in = '0; y_in = '0; colour_in = '0; plot_in = 1'b0;
    clear_req = 1'b0; clear_colour = '0; mem.mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we", 32'(mem.mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_offs", 32'(offscreen), 0);
    // single pixel, two-cycle latency
    mem.mem_ready = 1'b1;
    x_in = 5; y_in = 2; colour_in = 3'b101; plot_in = 1'b1;
    expect_wr(325, 5);
    tick();
    plot_in = 1'b0;
    chk("lat_n1_we", 32'(mem.mem_we), 0);
    tick();
    chk("lat_n2_we", 32'(mem.mem_we), 1);
    chk("lat_n2_addr", 32'(mem.mem_addr), 325);
    chk("lat_n2_data", 32'(mem.mem_data), 5);
    tick();
    chk("single_done_we", 32'(mem.mem_we), 0);
    chk("single_done_busy", 32'(busy), 0);
    // off-screen pixels
    x_in = 160; y_in = 0; plot_in = 1'b1;
    tick();
    chk("offs1", 32'(offscreen), 1);
    x_in = 0; y_in = 120;
    tick();
    chk("offs2", 32'(offscreen), 1);
    plot_in = 1'b0;
    tick();
    chk("offs_end", 32'(offscreen), 0);
    chk("offs_busy", 32'(busy), 0);
    chk("offs_we", 32'(mem.mem_we), 0);
    // 4x4 square burst, memory ready one cycle in five: pixels 0..10 and 14 survive,
    // 11..13 and 15 hit a full FIFO
    for (int i = 0; i < 16; i++) begin
      x_in = 12'(10 + i % 4); y_in = 11'(20 + i / 4); colour_in = 3'(i);
      plot_in = 1'b1;
      mem.mem_ready = (i % 5 == 4);
      if (i <= 10 || i == 14) expect_wr((20 + i / 4) * 160 + 10 + i % 4, i % 8);
      tick();
    end
    plot_in = 1'b0;
    mem.mem_ready = 1'b1;
    chk("burst_ovf", 32'(overflow), 1);
    wait_idle(200);
    chk("burst_q_empty", 32'(exp_q.size()), 0);
    // reset in the middle of a stalled write
    mem.mem_ready = 1'b0;
    x_in = 1; y_in = 1; colour_in = 3; plot_in = 1'b1;
    tick();
    plot_in = 1'b0;
    tick();
    chk("pre_rst_we", 32'(mem.mem_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(mem.mem_we), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ovf", 32'(overflow), 0);
    tick();
    reset = 1'b0;
    mem.mem_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_we", 32'(mem.mem_we), 0);
    chk("post_rst_busy", 32'(busy), 0);
    // clear behind three queued pixels
    mem.mem_ready = 1'b0;
    x_in = 3; y_in = 4; colour_in = 2; plot_in = 1'b1; expect_wr(4 * 160 + 3, 2);
    tick();
    x_in = 7; y_in = 8; colour_in = 3; expect_wr(8 * 160 + 7, 3);
    tick();
    x_in = 100; y_in = 50; colour_in = 4; expect_wr(50 * 160 + 100, 4);
    tick();
    plot_in = 1'b0;
    clear_req = 1'b1; clear_colour = 3'b001;
    for (int a = 0; a < 19200; a++) expect_wr(a, 1);
    tick();
    clear_req = 1'b0;
    mem.mem_ready = 1'b1;
    wait_idle(25000);
    chk("clear_q_empty", 32'(exp_q.size()), 0);
    chk("clear_done_we", 32'(mem.mem_we), 0);
    // pixel drawn mid-clear lands after the clear
    clear_req = 1'b1; clear_colour = 3'b010;
    for (int a = 0; a < 19200; a++) expect_wr(a, 2);
    tick();
    clear_req = 1'b0;
    begin
      int n = 0;
      while (!(mem.mem_we && mem.mem_addr == 15'd100) && n < 300) begin
        tick();
        n++;
      end
      chk("reach_addr100", 32'(mem.mem_addr), 100);
    end
    x_in = 0; y_in = 0; colour_in = 7; plot_in = 1'b1;
    expect_wr(0, 7);
    tick();
    plot_in = 1'b0;
    chk("mid_clear_busy", 32'(busy), 1);
    wait_idle(25000);
    chk("plot_clear_q_empty", 32'(exp_q.size()), 0);
    chk("final_ovf", 32'(overflow), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
